// File: rtl/regfile_writeback_if.sv
// Writeback bundle: ALU and memory sources, register file write port,
// and decode hazard taps. Bypass taps exist only with WB_BYPASS_EN.
interface regfile_writeback_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        RegWEn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_rs1;
    logic        busy_rs2;
`ifdef WB_BYPASS_EN
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_rs1_data;
    logic [31:0] fwd_rs2_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1_addr, rs2_addr,
        output alu_ready, mem_ready,
        output RegWEn, rd_addr, rd_data,
        output busy_rs1, busy_rs2,
        output fwd_rs1_hit, fwd_rs2_hit,
        output fwd_rs1_data, fwd_rs2_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1_addr, rs2_addr,
        input  alu_ready, mem_ready,
        input  RegWEn, rd_addr, rd_data,
        input  busy_rs1, busy_rs2,
        input  fwd_rs1_hit, fwd_rs2_hit,
        input  fwd_rs1_data, fwd_rs2_data
    );
`else
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  rs1_addr, rs2_addr,
        output alu_ready, mem_ready,
        output RegWEn, rd_addr, rd_data,
        output busy_rs1, busy_rs2
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output rs1_addr, rs2_addr,
        input  alu_ready, mem_ready,
        input  RegWEn, rd_addr, rd_data,
        input  busy_rs1, busy_rs2
    );
`endif
endinterface

// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: ALU source vs. in-order memory FIFO.
// Optional WB_BYPASS_EN adds output-stage forwarding taps for decode.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    regfile_writeback_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];

    logic          out_we;
    logic [4:0]    out_rd;
    logic [31:0]   out_data;

    logic full;
    logic empty;
    logic alu_win;
    logic push;
    logic pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign wb.mem_ready = !rst && !full;
    assign wb.alu_ready = !rst && !full;

    // x0 requests complete the handshake but never reach the queue or port
    assign alu_win = !full && wb.alu_valid && (wb.alu_rd != 5'd0);
    assign push    = wb.mem_valid && !full && (wb.mem_rd != 5'd0);
    assign pop     = !alu_win && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_we   <= 1'b0;
            out_rd   <= 5'd0;
            out_data <= 32'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                out_we   <= 1'b1;
                out_rd   <= q_rd[rd_ptr];
                out_data <= q_data[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (alu_win) begin
                out_we   <= 1'b1;
                out_rd   <= wb.alu_rd;
                out_data <= wb.alu_data;
            end else begin
                out_we   <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_rd[wr_ptr]   <= wb.mem_rd;
            q_data[wr_ptr] <= wb.mem_data;
        end
    end

    assign wb.RegWEn  = out_we;
    assign wb.rd_addr = out_rd;
    assign wb.rd_data = out_data;

    logic fifo_hit1;
    logic fifo_hit2;

    // Only the count entries starting at the read pointer are live
    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (q_rd[rd_ptr + AW'(k)] == wb.rs1_addr) fifo_hit1 = 1'b1;
                if (q_rd[rd_ptr + AW'(k)] == wb.rs2_addr) fifo_hit2 = 1'b1;
            end
        end
    end

    logic out_hit1;
    logic out_hit2;
    logic nz1;
    logic nz2;

    assign nz1      = (wb.rs1_addr != 5'd0);
    assign nz2      = (wb.rs2_addr != 5'd0);
    assign out_hit1 = out_we && (out_rd == wb.rs1_addr);
    assign out_hit2 = out_we && (out_rd == wb.rs2_addr);

`ifdef WB_BYPASS_EN
    assign wb.fwd_rs1_hit  = out_hit1 && nz1;
    assign wb.fwd_rs2_hit  = out_hit2 && nz2;
    assign wb.fwd_rs1_data = out_data;
    assign wb.fwd_rs2_data = out_data;

    assign wb.busy_rs1 = nz1 && (fifo_hit1 || (out_hit1 && !wb.fwd_rs1_hit));
    assign wb.busy_rs2 = nz2 && (fifo_hit2 || (out_hit2 && !wb.fwd_rs2_hit));
`else
    assign wb.busy_rs1 = nz1 && (fifo_hit1 || out_hit1);
    assign wb.busy_rs2 = nz2 && (fifo_hit2 || out_hit2);
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed table, corner sequences, and
// random traffic against a queue-based model of the writeback rules.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    regfile_writeback_if w();

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic        av, mv, rst_i;
    logic [4:0]  ard, mrd, rs1, rs2;
    logic [31:0] ad, md;
    logic        rdy;

    ent_t        q[$];
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic [4:0]  wlog[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic mbusy(logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].rd == rs) return 1'b1;
`ifdef WB_BYPASS_EN
        return 1'b0;
`else
        return e_we && (e_rd == rs);
`endif
    endfunction

    task automatic pop_head();
        e_we = 1'b1;
        e_rd = q[0].rd;
        e_d  = q[0].d;
        void'(q.pop_front());
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic cyc();
        rst         = rst_i;
        w.alu_valid = av;
        w.alu_rd    = ard;
        w.alu_data  = ad;
        w.mem_valid = mv;
        w.mem_rd    = mrd;
        w.mem_data  = md;
        w.rs1_addr  = rs1;
        w.rs2_addr  = rs2;
        #1;
        rdy = !rst_i && (q.size() != DEPTH);
        chk("alu_ready", w.alu_ready, rdy);
        chk("mem_ready", w.mem_ready, rdy);
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            e_we = 1'b0;
            e_rd = 5'd0;
            e_d  = 32'd0;
        end else begin
            if (q.size() == DEPTH) pop_head();
            else if (av && ard != 5'd0) begin
                e_we = 1'b1;
                e_rd = ard;
                e_d  = ad;
            end else if (q.size() > 0) pop_head();
            else e_we = 1'b0;
            if (rdy && mv && mrd != 5'd0) q.push_back('{mrd, md});
        end
        @(negedge clk);
        chk("RegWEn", w.RegWEn, e_we);
        if (e_we) begin
            chk("rd_addr", w.rd_addr, e_rd);
            chk("rd_data", w.rd_data, e_d);
        end
        chk("busy_rs1", w.busy_rs1, mbusy(rs1));
        chk("busy_rs2", w.busy_rs2, mbusy(rs2));
`ifdef WB_BYPASS_EN
        chk("fwd_rs1_hit", w.fwd_rs1_hit, e_we && rs1 == e_rd && rs1 != 0);
        chk("fwd_rs2_hit", w.fwd_rs2_hit, e_we && rs2 == e_rd && rs2 != 0);
        if (e_we) chk("fwd_rs1_data", w.fwd_rs1_data, e_d);
`endif
        if (w.RegWEn) wlog.push_back(w.rd_addr);
    endtask

    task automatic idle_in();
        av = 1'b0; ard = 5'd0; ad = 32'd0;
        mv = 1'b0; mrd = 5'd0; md = 32'd0;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,   1'b1, 5'd5, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0};
        tbl[2] = '{1'b0, 5'd0, 32'd0,        1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'd0};
        tbl[3] = '{1'b1, 5'd3, 32'hAA,       1'b0, 5'd0, 32'd0,   1'b1, 5'd3, 32'hAA};
        tbl[4] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b1, 5'd7, 32'h1234};
        tbl[5] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0};
        tbl[6] = '{1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66,  1'b0, 5'd0, 32'd0};
        tbl[7] = '{1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b0, 5'd0, 32'd0};

        e_we = 1'b0; e_rd = 5'd0; e_d = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0;
        idle_in();
        rst_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        // reset held 3 cycles with a live ALU request
        av = 1'b1; ard = 5'd5; ad = 32'h11;
        rs1 = 5'd5; rs2 = 5'd5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_we", w.RegWEn, 1'b0);
            chk("rst_busy", w.busy_rs1, 1'b0);
        end
        chk("rst_rd_addr", w.rd_addr, 32'd0);
        chk("rst_rd_data", w.rd_data, 32'd0);
        rst_i = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0;

        foreach (tbl[i]) begin
            av = tbl[i].av; ard = tbl[i].ard; ad = tbl[i].ad;
            mv = tbl[i].mv; mrd = tbl[i].mrd; md = tbl[i].md;
            cyc();
            chk($sformatf("tbl%0d_we", i), w.RegWEn, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_rd", i), w.rd_addr, tbl[i].rd);
                chk($sformatf("tbl%0d_data", i), w.rd_data, tbl[i].d);
            end
        end

        begin : five_mem
            int k;
            logic saw_low;
            logic saw_alu_stall;
            int got[$];
            k = 0;
            saw_low = 1'b0;
            saw_alu_stall = 1'b0;
            wlog.delete();
            for (int c = 0; c < 30; c++) begin
                mv = (k < 5); mrd = 5'(k + 1); md = 32'h100 + k;
                av = (c < 12); ard = 5'd20; ad = c;
                cyc();
                if (!rdy) saw_low = 1'b1;
                if (!rdy && av) saw_alu_stall = 1'b1;
                if (mv && rdy) k++;
            end
            idle_in();
            foreach (wlog[i]) if (wlog[i] <= 5'd5) got.push_back(int'(wlog[i]));
            chk("five_accepted", k, 5);
            chk("mem_ready_drop", saw_low, 1'b1);
            chk("alu_stalled_full", saw_alu_stall, 1'b1);
            chk("five_retired", got.size(), 5);
            foreach (got[i]) chk($sformatf("order%0d", i), got[i], i + 1);
        end

        // hazard on a queued load
        rs1 = 5'd9; rs2 = 5'd0;
        mv = 1'b1; mrd = 5'd9; md = 32'h99;
        cyc();
        chk("haz_queued", w.busy_rs1, 1'b1);
        idle_in();
        cyc();
        chk("haz_we", w.RegWEn, 1'b1);
        chk("haz_rd", w.rd_addr, 5'd9);
        chk("haz_rs2", w.busy_rs2, 1'b0);
`ifdef WB_BYPASS_EN
        chk("haz_out_busy", w.busy_rs1, 1'b0);
        chk("haz_fwd_hit", w.fwd_rs1_hit, 1'b1);
`else
        chk("haz_out_busy", w.busy_rs1, 1'b1);
`endif
        cyc();
        chk("haz_clear", w.busy_rs1, 1'b0);
        rs1 = 5'd0;

        // reset with queued writes discards them
        av = 1'b1; ard = 5'd6; ad = 32'h6;
        for (int i = 0; i < 3; i++) begin
            mv = 1'b1; mrd = 5'(i + 10); md = i;
            cyc();
        end
        idle_in();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_reset_we", w.RegWEn, 1'b0);
        end

        for (int i = 0; i < 400; i++) begin
            av  = 1'($urandom_range(0, 1));
            ard = 5'($urandom_range(0, 7));
            ad  = $urandom;
            mv  = 1'($urandom_range(0, 1));
            mrd = 5'($urandom_range(0, 7));
            md  = $urandom;
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            rst_i = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
